prog_sequence_detector: RTL

//   Runtime-programmable serial pattern detector for a 1-bit input stream, with two pattern slots (A, B).

---
 rtl/prog_sequence_detector_if.sv | 43 ++++
 rtl/prog_sequence_detector.sv | 104 ++++++++++
 2 files changed

// File: rtl/prog_sequence_detector_if.sv
// prog_sequence_detector_if
//   Bundles the stream, configuration and result signals of the
//   programmable dual-slot sequence detector.
//   master : drives stream / config / counter clear, observes hits and counts
//   slave  : the detector itself
//   Signals:
//     x_valid, x        serial stream bit and its qualifier
//     overlap           1 = overlapping detection, 0 = non-overlapping
//     cfg_we, cfg_sel   write strobe and slot select (0 = A, 1 = B)
//     cfg_pattern       pattern, bit [len-1] received first, bit [0] last
//     cfg_len           pattern length, 0 disables the slot
//     cnt_clear         synchronous clear of both hit counters
//     hit_a, hit_b      same-cycle match flags
//     cnt_a, cnt_b      saturating hit counters
interface prog_sequence_detector_if #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8
);
  localparam int LW = $clog2(MAX_LEN + 1);

  logic               x_valid;
  logic               x;
  logic               overlap;
  logic               cfg_we;
  logic               cfg_sel;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LW-1:0]      cfg_len;
  logic               cnt_clear;
  logic               hit_a;
  logic               hit_b;
  logic [CNT_W-1:0]   cnt_a;
  logic [CNT_W-1:0]   cnt_b;

  modport master (
    output x_valid, x, overlap, cfg_we, cfg_sel, cfg_pattern, cfg_len, cnt_clear,
    input  hit_a, hit_b, cnt_a, cnt_b
  );

  modport slave (
    input  x_valid, x, overlap, cfg_we, cfg_sel, cfg_pattern, cfg_len, cnt_clear,
    output hit_a, hit_b, cnt_a, cnt_b
  );
endinterface

// File: rtl/prog_sequence_detector.sv
// prog_sequence_detector
//   Runtime-programmable serial pattern detector with two slots (A, B).
//   Each slot holds a pattern of 1..MAX_LEN bits; matches are reported in the
//   same cycle as the final bit (Mealy) and counted in saturating counters.
//   Overlapping or non-overlapping detection is selected per cycle.
//   Ports:
//     clk      rising-edge clock
//     reset_n  asynchronous active-low reset
//     bus      prog_sequence_detector_if.slave (stream, config, hits, counts)
module prog_sequence_detector #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  prog_sequence_detector_if.slave  bus
);
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int HW = MAX_LEN - 1;

  localparam logic [MAX_LEN:0] MASK_ONE = (MAX_LEN + 1)'(1);
  localparam logic [LW:0]      FILL_ONE = (LW + 1)'(1);
  localparam logic [LW-1:0]    FILL_MAX = LW'(MAX_LEN - 1);
  localparam logic [LW-1:0]    LEN_MAX  = LW'(MAX_LEN);

  // Low-order mask covering the last len bits of the window.
  function automatic logic [MAX_LEN-1:0] len_mask(input logic [LW-1:0] len);
    logic [MAX_LEN:0] m;
    m = (MASK_ONE << len) - MASK_ONE;
    return m[MAX_LEN-1:0];
  endfunction

  logic [HW-1:0]             hist_reg;
  logic [LW-1:0]             fill_reg;
  logic [MAX_LEN-1:0]        window;
  logic [LW-1:0]             cfg_len_clamped;
  logic [1:0]                hit;
  logic [1:0][CNT_W-1:0]     cnt;

  // Current bit sits at window[0]; older bits above it.
  assign window          = {hist_reg, bus.x};
  assign cfg_len_clamped = (bus.cfg_len > LEN_MAX) ? LEN_MAX : bus.cfg_len;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_slot
      logic [MAX_LEN-1:0] pat_reg;
      logic [LW-1:0]      len_reg;
      logic [CNT_W-1:0]   cnt_reg;
      logic [MAX_LEN-1:0] mask;
      logic               enough_bits;

      assign mask        = len_mask(len_reg);
      // fill+1 >= len, computed one bit wider so len=0 cannot underflow.
      assign enough_bits = ({1'b0, fill_reg} + FILL_ONE) >= {1'b0, len_reg};
      assign hit[gi]     = bus.x_valid && (len_reg != '0) && enough_bits &&
                           (((window ^ pat_reg) & mask) == '0);
      assign cnt[gi]     = cnt_reg;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          pat_reg <= '0;
          len_reg <= '0;
          cnt_reg <= '0;
        end else begin
          if (bus.cfg_we && (bus.cfg_sel == 1'(gi))) begin
            pat_reg <= bus.cfg_pattern;
            len_reg <= cfg_len_clamped;
          end
          if (bus.cnt_clear) begin
            cnt_reg <= '0;
          end else if (hit[gi] && (cnt_reg != '1)) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
      end
    end
  endgenerate

  // History shift register and fill level shared by both slots. A config
  // write restarts detection; in non-overlap mode any hit consumes the bits.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hist_reg <= '0;
      fill_reg <= '0;
    end else begin
      if (bus.x_valid) begin
        hist_reg <= window[HW-1:0];
      end
      if (bus.cfg_we) begin
        fill_reg <= '0;
      end else if (!bus.overlap && (|hit)) begin
        fill_reg <= '0;
      end else if (bus.x_valid && (fill_reg != FILL_MAX)) begin
        fill_reg <= fill_reg + LW'(1);
      end
    end
  end

  assign bus.hit_a = hit[0];
  assign bus.hit_b = hit[1];
  assign bus.cnt_a = cnt[0];
  assign bus.cnt_b = cnt[1];
endmodule
